// File: rtl/csirx_pkg.sv
// Shared types for the CSI receive path: pixel word width, framer states
// and the FIFO entry carrying frame markers alongside the pixel data.
package csirx_pkg;

    localparam int PIX_WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        DROP   = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [PIX_WORD_W-1:0] data;
    } fifo_entry_t;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally from storage, so a word written into an empty FIFO is
// visible the cycle after the write. Read and write may coincide at any
// occupancy, including full.
module axis_fifo_fwft #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en_i && !empty_o;
    // A write while full only lands if the head is leaving in the same cycle.
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    // Empty FIFO presents zeros so idle outputs never carry stale data.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Occupancy update for the four read/write combinations.
    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage array; contents are qualified by occupancy so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/csi_axis_framer.sv
// Frames the non-stallable CSI pixel stream into AXI4-Stream video
// (tuser = start of frame, tlast = end of line), buffers it against
// downstream backpressure and drops the remainder of a frame on overflow.
//
// state  | meaning
// IDLE   | between frames, input words ignored
// ACTIVE | capturing words of the current frame into the FIFO
// DONE   | full frame captured, any further word is a frame error
// DROP   | FIFO overflowed, rest of this frame discarded
module csi_axis_framer
    import csirx_pkg::*;
#(
    parameter int WORDS_PER_LINE  = 480,
    parameter int LINES_PER_FRAME = 1080,
    parameter int FIFO_DEPTH      = 64
) (
    input  logic                  rxbyteclkhs,
    input  logic                  rxbyteclkhs_resetn,
    input  logic                  frame_active,
    input  logic                  s_valid,
    input  logic [PIX_WORD_W-1:0] s_data,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [PIX_WORD_W-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  clear_status,
    output logic                  overflow,
    output logic                  frame_err,
    output logic [15:0]           frame_count
);

    localparam int COL_W = cnt_w(WORDS_PER_LINE);
    localparam int ROW_W = cnt_w(LINES_PER_FRAME);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES_PER_FRAME - 1);

    fsm_state_e       state_q, state_d;
    logic             fa_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             fa_rise, fa_fall;
    logic             set_ovf, set_err;
    logic             wr_en, rd_en, write_ok;
    logic             fifo_full, fifo_empty;
    fifo_entry_t      wr_entry, head;

    assign fa_rise  = frame_active && !fa_q;
    assign fa_fall  = !frame_active && fa_q;
    assign rd_en    = !fifo_empty && m_axis_tready;
    assign write_ok = !fifo_full || rd_en;

    // Framer FSM, column/row tracking and status set/clear.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        frame_count_d = frame_count_q;
        set_ovf       = 1'b0;
        set_err       = 1'b0;
        wr_en         = 1'b0;
        wr_entry.sof  = (col_q == '0) && (row_q == '0);
        wr_entry.eol  = (col_q == COL_LAST);
        wr_entry.data = s_data;

        // A rise always restarts the frame; the word on that cycle is not captured.
        if (fa_rise) begin
            set_err = (state_q == ACTIVE);
            state_d = ACTIVE;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (fa_fall) begin
                        set_err = 1'b1;
                        state_d = IDLE;
                    end else if (s_valid) begin
                        if (write_ok) begin
                            wr_en = 1'b1;
                            if (wr_entry.eol) begin
                                col_d = '0;
                                if (row_q == ROW_LAST) begin
                                    row_d         = '0;
                                    frame_count_d = frame_count_q + 16'd1;
                                    state_d       = DONE;
                                end else begin
                                    row_d = row_q + ROW_W'(1);
                                end
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end else begin
                            set_ovf = 1'b1;
                            state_d = DROP;
                        end
                    end
                end
                DONE: begin
                    if (fa_fall) begin
                        state_d = IDLE;
                    end else if (s_valid) begin
                        set_err = 1'b1;
                    end
                end
                DROP: begin
                    if (fa_fall) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Sticky flags: a set in the same cycle as a clear wins.
        overflow_d  = (overflow_q && !clear_status) || set_ovf;
        frame_err_d = (frame_err_q && !clear_status) || set_err;
    end

    // State, counters and status registers.
    always_ff @(posedge rxbyteclkhs or negedge rxbyteclkhs_resetn) begin
        if (!rxbyteclkhs_resetn) begin
            state_q       <= IDLE;
            fa_q          <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fa_q          <= frame_active;
            col_q         <= col_d;
            row_q         <= row_d;
            overflow_q    <= overflow_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    axis_fifo_fwft #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (rxbyteclkhs),
        .rst_n_i   (rxbyteclkhs_resetn),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_entry),
        .rd_en_i   (rd_en),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = head.data;
    assign m_axis_tuser  = head.sof;
    assign m_axis_tlast  = head.eol;
    assign overflow      = overflow_q;
    assign frame_err     = frame_err_q;
    assign frame_count   = frame_count_q;

endmodule
